// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_pkg
// Brief    : Shared constants and stamp type for the sequence-detector slice.
// Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef logic [TS_W_DEF-1:0] stamp_t;

endpackage
`default_nettype wire

// File: rtl/hit_ts_fifo.sv
`default_nettype none
// ============================================================================
// Module   : hit_ts_fifo
// Brief    : Small synchronous FIFO with registered head output and flush.
// Revision : 1.0 - initial release
// ============================================================================
module hit_ts_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int                   c_aw       = $clog2(DEPTH);
    localparam logic [c_aw:0]        c_lvl_full = (c_aw+1)'(DEPTH);
    localparam logic [c_aw:0]        c_lvl_one  = (c_aw+1)'(1);

    logic [W-1:0]    r_mem [DEPTH];
    logic [W-1:0]    r_dout;
    logic [c_aw-1:0] r_rptr;
    logic [c_aw-1:0] r_wptr;
    logic [c_aw-1:0] w_rptr_nxt;
    logic [c_aw:0]   r_level;
    logic            w_do_push;
    logic            w_do_pop;

    assign empty      = (r_level == '0);
    assign full       = (r_level == c_lvl_full);
    assign w_do_pop   = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_do_push  = push & (~full | w_do_pop);
    assign w_rptr_nxt = r_rptr + 1'b1;
    assign dout       = r_dout;
    assign level      = r_level;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_level <= '0;
            r_dout  <= '0;
        end else if (flush) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= w_rptr_nxt;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            // Head register: next stored entry, or the incoming word if it becomes the head.
            if (w_do_pop && (r_level > c_lvl_one)) begin
                r_dout <= r_mem[w_rptr_nxt];
            end else if (w_do_push && (empty || (w_do_pop && r_level == c_lvl_one))) begin
                r_dout <= din;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_hit_logger.sv
`default_nettype none
// ============================================================================
// Module   : seq_hit_logger
// Brief    : Timestamps qualified detector hits, buffers them, counts them.
// Revision : 1.0 - initial release
// ============================================================================
module seq_hit_logger
    import seq_det_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bit_en,
    input  logic                     hit_i,
    input  logic                     clr,
    output logic [TS_W-1:0]          ts_data,
    output logic                     ts_valid,
    input  logic                     ts_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         hit_count,
    output logic                     overflow
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic [TS_W-1:0]  r_bidx;
    logic [CNT_W-1:0] r_hit_count;
    logic             r_overflow;
    logic             w_hit;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;

    assign w_hit  = hit_i & bit_en;
    // Clear wins over anything else arriving in the same cycle.
    assign w_push = w_hit & ~clr;
    assign w_pop  = ts_ready & ~clr;

    hit_ts_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (clr),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_bidx),
        .dout  (ts_data),
        .level (level),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bidx      <= '0;
            r_hit_count <= '0;
            r_overflow  <= 1'b0;
        end else if (clr) begin
            r_bidx      <= '0;
            r_hit_count <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (bit_en) begin
                r_bidx <= r_bidx + 1'b1;
            end
            if (w_hit && (r_hit_count != c_cnt_max)) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
            // Full implies non-empty, so ts_ready alone means a slot frees up.
            if (w_hit && w_full && !ts_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign ts_valid  = ~w_empty;
    assign hit_count = r_hit_count;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seq_hit_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_hit_logger
// Brief    : Directed self-checking bench with a stamp scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_hit_logger;
    import seq_det_pkg::*;

    localparam int c_depth = 4;
    localparam int c_cnt_w = 3;

    logic                      clk;
    logic                      rst;
    logic                      bit_en;
    logic                      hit_i;
    logic                      clr;
    logic                      ts_ready;
    stamp_t                    ts_data;
    logic                      ts_valid;
    logic [$clog2(c_depth):0]  level;
    logic [c_cnt_w-1:0]        hit_count;
    logic                      overflow;

    seq_hit_logger #(
        .TS_W  (TS_W_DEF),
        .DEPTH (c_depth),
        .CNT_W (c_cnt_w)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bit_en    (bit_en),
        .hit_i     (hit_i),
        .clr       (clr),
        .ts_data   (ts_data),
        .ts_valid  (ts_valid),
        .ts_ready  (ts_ready),
        .level     (level),
        .hit_count (hit_count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    stamp_t q[$];
    stamp_t popped[$];
    stamp_t m_bidx;
    int     m_cnt;
    logic   m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_bidx = '0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
    endtask

    // Called just after a falling edge: check current state, drive inputs, advance model.
    task automatic step(input logic be, input logic hi, input logic rd, input logic cl);
        logic do_pop;
        logic do_push;
        chk("ts_valid", {31'd0, ts_valid}, {31'd0, (q.size() != 0)});
        chk("level", {29'd0, level}, q.size());
        chk("hit_count", {29'd0, hit_count}, m_cnt);
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        if (q.size() != 0) begin
            chk("ts_data", {16'd0, ts_data}, {16'd0, q[0]});
        end
        bit_en   = be;
        hit_i    = hi;
        ts_ready = rd;
        clr      = cl;
        if (cl) begin
            model_reset();
        end else begin
            do_pop  = rd && (q.size() != 0);
            do_push = 1'b0;
            if (be && hi) begin
                if (m_cnt < 7) m_cnt++;
                if (q.size() == c_depth && !do_pop) m_ovf = 1'b1;
                else do_push = 1'b1;
            end
            if (do_pop) begin
                popped.push_back(ts_data);
                void'(q.pop_front());
            end
            if (do_push) q.push_back(m_bidx);
            if (be) m_bidx = m_bidx + 1'b1;
        end
        @(negedge clk);
        {bit_en, hit_i, ts_ready, clr} = 4'b0000;
    endtask

    logic [8:0] stream;
    logic [3:0] det_sh;
    int         det_n;
    logic       det_hit;
    logic       b;

    initial begin
        rst = 1'b0; bit_en = 1'b0; hit_i = 1'b0; clr = 1'b0; ts_ready = 1'b0;
        model_reset();

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, ts_valid}, 0);
        chk("rst_level", {29'd0, level}, 0);
        chk("rst_data", {16'd0, ts_data}, 0);
        chk("rst_count", {29'd0, hit_count}, 0);
        chk("rst_ovf", {31'd0, overflow}, 0);
        rst = 1'b1;
        repeat (10) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        popped.delete();
        step(0, 0, 1, 0);
        chk("idle_stamp", popped.size() == 1 ? popped[0] : 16'hffff, 10);
        step(0, 0, 0, 1);

        // 1101 stream through a non-overlapping detector
        stream = 9'b110111010;
        det_sh = '0; det_n = 0;
        popped.delete();
        for (int i = 0; i < 9; i++) begin
            b       = stream[8-i];
            det_hit = (det_n >= 3) && ({det_sh[2:0], b} == 4'b1101);
            det_sh  = {det_sh[2:0], b};
            det_n   = det_hit ? 0 : det_n + 1;
            step(1, det_hit, 1, 0);
        end
        repeat (2) step(0, 0, 1, 0);
        chk("det_npop", popped.size(), 2);
        chk("det_first", popped.size() > 0 ? popped[0] : 16'hffff, 3);
        chk("det_second", popped.size() > 1 ? popped[1] : 16'hffff, 7);
        chk("det_count", {29'd0, hit_count}, 2);
        step(0, 0, 0, 1);

        // Gapped bit_en: hits without bit_en are ignored
        popped.delete();
        step(0, 1, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        repeat (3) step(0, 0, 1, 0);
        chk("gap_first", popped.size() > 0 ? popped[0] : 16'hffff, 1);
        chk("gap_second", popped.size() > 1 ? popped[1] : 16'hffff, 2);
        chk("gap_count", {29'd0, hit_count}, 2);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);

        // Overflow with consumer stalled
        popped.delete();
        repeat (6) step(1, 1, 0, 0);
        chk("ovf_level", {29'd0, level}, 4);
        chk("ovf_flag", {31'd0, overflow}, 1);
        chk("ovf_count", {29'd0, hit_count}, 6);
        repeat (5) step(0, 0, 1, 0);
        for (int i = 0; i < 4; i++)
            chk("ovf_drain", popped.size() > i ? popped[i] : 16'hffff, i);
        chk("ovf_sticky", {31'd0, overflow}, 1);
        step(0, 0, 0, 1);

        // Full with simultaneous push and pop
        popped.delete();
        repeat (4) step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        chk("fpp_level", {29'd0, level}, 4);
        chk("fpp_ovf", {31'd0, overflow}, 0);
        repeat (5) step(0, 0, 1, 0);
        chk("fpp_npop", popped.size(), 5);
        chk("fpp_last", popped.size() == 5 ? popped[4] : 16'hffff, 4);
        step(0, 0, 0, 1);

        // Saturation and clear with a coincident hit
        repeat (9) step(1, 1, 1, 0);
        chk("sat_count", {29'd0, hit_count}, 7);
        step(1, 1, 1, 1);
        chk("clr_count", {29'd0, hit_count}, 0);
        chk("clr_level", {29'd0, level}, 0);
        chk("clr_ovf", {31'd0, overflow}, 0);
        step(1, 1, 0, 0);
        chk("clr_stamp", {16'd0, ts_data}, 0);
        step(0, 0, 1, 0);

        // Asynchronous reset mid-operation
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        ts_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ts_valid}, 0);
        chk("arst_level", {29'd0, level}, 0);
        chk("arst_count", {29'd0, hit_count}, 0);
        model_reset();
        @(negedge clk);
        ts_ready = 1'b0;
        rst = 1'b1;
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("arst_stamp", {16'd0, ts_data}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
